// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: slice function codes,
// function-code bit positions and the sequencer state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

  localparam int F_EN_B  = 2;
  localparam int F_INV_A = 3;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, shift-right register with serial input at the MSB and serial
// output from the LSB. Load has priority over shift.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= '0;
    end else if (load_i) begin
      r_q <= load_data_i;
    end else if (shift_i) begin
      r_q <= {ser_i, r_q[WIDTH-1:1]};
    end
  end

  assign ser_o = r_q[0];
  assign q_o   = r_q;

endmodule

// File: rtl/bit_serial_alu_sequencer.sv
// Issues operand bit pairs LSB-first to an external one-bit ALU slice and assembles
// its result. Optional ZERO_FLAG_EN adds zero_o, a serially accumulated all-zero flag.
module bit_serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
`ifdef ZERO_FLAG_EN
  output logic             zero_o,
`endif
  output logic             alu_a_o,
  output logic             alu_b_o,
  output logic             alu_carry_o,
  output logic [3:0]       alu_f_o,
  input  logic             alu_result_i,
  input  logic             alu_carry_i
);

  localparam int CW = $clog2(WIDTH);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_op;
  logic            r_carry;
  logic            r_carry_out;
  logic            w_accept;
  logic            w_run;
  logic            w_last;
  logic            w_a_bit;
  logic            w_b_bit;
  logic            w_res_ser;
  logic [WIDTH-1:0] w_a_par;
  logic [WIDTH-1:0] w_b_par;
  logic [WIDTH-1:0] w_res_q;
  logic            w_unused;

  assign w_accept = (r_state == ST_IDLE) && start_i;
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = w_run && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Subtract (invert A + ADD) needs the +1 of two's complement as the initial carry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= op_i;
      r_carry <= op_i[F_INV_A] && (op_i[1:0] == OP_ADD);
    end else if (w_run) begin
      r_cnt   <= r_cnt + CW'(1);
      r_carry <= alu_carry_i;
      if (w_last) r_carry_out <= (r_op[1:0] == OP_ADD) && alu_carry_i;
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_reg (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(w_accept), .load_data_i(a_i),
    .shift_i(w_run), .ser_i(1'b0), .ser_o(w_a_bit), .q_o(w_a_par)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(w_accept), .load_data_i(b_i),
    .shift_i(w_run), .ser_i(1'b0), .ser_o(w_b_bit), .q_o(w_b_par)
  );

  // Never loaded: the previous result stays visible until the next run shifts it out.
  serial_shift_reg #(.WIDTH(WIDTH)) u_res_reg (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(1'b0), .load_data_i('0),
    .shift_i(w_run), .ser_i(alu_result_i), .ser_o(w_res_ser), .q_o(w_res_q)
  );

  assign w_unused = ^{w_a_par, w_b_par, w_res_ser};

`ifdef ZERO_FLAG_EN
  logic r_nz;
  logic r_zero;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_nz <= 1'b0;
    end else if (w_run) begin
      r_nz <= r_nz | alu_result_i;
      if (w_last) r_zero <= ~(r_nz | alu_result_i);
    end
  end

  assign zero_o = r_zero;
`endif

  assign busy_o      = w_run;
  assign done_o      = (r_state == ST_DONE);
  assign result_o    = w_res_q;
  assign carry_o     = r_carry_out;
  assign alu_a_o     = w_run & w_a_bit;
  assign alu_b_o     = w_run & w_b_bit;
  assign alu_carry_o = w_run & r_carry;
  assign alu_f_o     = r_op;

endmodule

// File: tb/tb_bit_serial_alu_sequencer.sv
// Scoreboard bench for bit_serial_alu_sequencer (WIDTH=8) driving a reference
// one-bit ALU slice; checks zero_o as well when ZERO_FLAG_EN is defined.
module tb_bit_serial_alu_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             carry_o;
  logic             zero_o;
  logic             alu_a_o;
  logic             alu_b_o;
  logic             alu_carry_o;
  logic [3:0]       alu_f_o;
  logic             alu_result_i;
  logic             alu_carry_i;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             zero;
    int               acc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   n_push = 0;
  int   cyc    = 0;

  bit_serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .carry_o(carry_o),
`ifdef ZERO_FLAG_EN
    .zero_o(zero_o),
`endif
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_carry_o(alu_carry_o), .alu_f_o(alu_f_o),
    .alu_result_i(alu_result_i), .alu_carry_i(alu_carry_i)
  );

`ifndef ZERO_FLAG_EN
  assign zero_o = 1'b0;
`endif

  // Reference one-bit ALU slice.
  logic w_sa, w_sb;
  always_comb begin
    w_sa         = alu_a_o ^ alu_f_o[F_INV_A];
    w_sb         = alu_b_o & alu_f_o[F_EN_B];
    alu_result_i = 1'b0;
    alu_carry_i  = 1'b0;
    case (alu_f_o[1:0])
      OP_AND: alu_result_i = w_sa & w_sb;
      OP_OR:  alu_result_i = w_sa | w_sb;
      OP_XOR: alu_result_i = w_sa ^ w_sb;
      default: begin
        alu_result_i = w_sa ^ w_sb ^ alu_carry_o;
        alu_carry_i  = (w_sa & w_sb) | (w_sa & alu_carry_o) | (w_sb & alu_carry_o);
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: pops one expectation per done_o pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done_o) begin
        n_done++;
        chk("done_expected", (q.size() != 0), 1);
        chk("busy_in_done", busy_o, 0);
        chk("alu_bits_in_done", {alu_a_o, alu_b_o, alu_carry_o}, 0);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("result", result_o, e.res);
          chk("carry", carry_o, e.carry);
          chk("latency", cyc - e.acc, WIDTH);
`ifdef ZERO_FLAG_EN
          chk("zero", zero_o, e.zero);
`endif
        end
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [7:0] er, input logic ec, input logic ez, input bit push);
    exp_t e;
    @(negedge clk);
    a_i = a; b_i = b; op_i = op; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (push) begin
      e.res = er; e.carry = ec; e.zero = ez; e.acc = cyc;
      q.push_back(e);
      n_push++;
    end
    chk("busy_after_accept", busy_o, 1);
    chk("f_latched", alu_f_o, op);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && !busy_o && !done_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk({"idle_", tag}, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    bit seen;
    rst_i = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_carry", carry_o, 0);
    chk("rst_alu", {alu_a_o, alu_b_o, alu_carry_o, alu_f_o}, 0);
    chk("rst_zero", zero_o, 0);
    @(negedge clk);
    rst_i = 1'b0;

    // ADD 5A + 33 = 8D, bit 0 of A is 0 and of B is 1.
    issue(8'h5A, 8'h33, 4'b0111, 8'h8D, 1'b0, 1'b0, 1'b1);
    chk("add_k0_a", alu_a_o, 0);
    chk("add_k0_b", alu_b_o, 1);
    chk("add_k0_cin", alu_carry_o, 0);
    wait_idle("add");
    repeat (3) @(posedge clk);
    #1;
    chk("result_hold", result_o, 8'h8D);
    chk("f_hold_idle", alu_f_o, 4'b0111);
    chk("alu_bits_idle", {alu_a_o, alu_b_o, alu_carry_o}, 0);

    // SUB: 35 - 10 = 25, no borrow so carry 1.
    issue(8'h10, 8'h35, 4'b1111, 8'h25, 1'b1, 1'b0, 1'b1);
    chk("sub_k0_cin", alu_carry_o, 1);
    wait_idle("sub");

    issue(8'hF0, 8'h3C, 4'b0100, 8'h30, 1'b0, 1'b0, 1'b1);
    wait_idle("and");
    issue(8'hFF, 8'hAA, 4'b0011, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_idle("b_dis");
    issue(8'h01, 8'hFF, 4'b0111, 8'h00, 1'b1, 1'b1, 1'b1);
    wait_idle("zero");

    // XOR with a start pulse in RUN cycle 3 and another during DONE.
    issue(8'hF0, 8'h3C, 4'b0110, 8'hCC, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_i = 8'h12; b_i = 8'h34; op_i = 4'b0111; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busy_mid_start", busy_o, 1);
    chk("f_mid_start", alu_f_o, 4'b0110);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("xor_done_seen", seen, 1);
    a_i = 8'h77; b_i = 8'h11; op_i = 4'b0111; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("done_start_ignored", busy_o, 0);
    chk("done_one_pulse", done_o, 0);
    chk("result_after_done_start", result_o, 8'hCC);
    wait_idle("xor");

    // Reset in RUN cycle 4: no completion expected.
    saved = n_done;
    issue(8'h5A, 8'h33, 4'b0111, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_busy_done", {busy_o, done_o}, 0);
    chk("midrst_result", result_o, 0);
    chk("midrst_carry", carry_o, 0);
    chk("midrst_alu", {alu_a_o, alu_b_o, alu_carry_o, alu_f_o}, 0);
    chk("midrst_zero", zero_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_rst", n_done, saved);

    issue(8'h5A, 8'h33, 4'b0111, 8'h8D, 1'b0, 1'b0, 1'b1);
    wait_idle("post_rst");

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    chk("done_count", n_done, n_push);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
